clock_divider: RTL and testbench
================================

// Module: clock_divider
// PURPOSE
//  Programmable integer divider producing the divided clock that feeds the four-phase
//  clock sync stage, plus a one-cycle tick at each divided-clock rising edge.
//  Divide ratio is runtime-loadable via valid/ready; new ratios take effect only at
//  a period boundary, so the output never has a runt or stretched pulse mid-period.
// PARAMETERS
//  c_WIDTH        16          width of divide ratio and internal counter
//  c_DEFAULT_DIV  16'd100     ratio N loaded at reset (elaboration error if < c_MIN_DIV)
//  c_MIN_DIV      16'd2       smallest legal ratio; smaller requests are rejected
// PORTS
//  i_clock        in   1        source clock; all logic on its rising edge
//  i_reset_n      in   1        asynchronous, active-low reset
//  i_enable       in   1        run request for the divided clock
//  i_div_value    in   c_WIDTH  requested ratio N (input clocks per output period)
//  i_div_valid    in   1        i_div_value valid
//  o_div_ready    out  1        divider can accept a new ratio
//  i_error_clear  in   1        clears o_error
//  o_clock_div    out  1        divided clock, registered, nominal 50% duty
//  o_tick         out  1        one-cycle pulse coincident with o_clock_div rising
//  o_active_div   out  c_WIDTH  ratio currently in effect
//  o_error        out  1        sticky: an illegal ratio was offered and dropped
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, count 0, o_clock_div 0, o_tick 0,
//   o_active_div = c_DEFAULT_DIV, pending empty, o_div_ready 1, o_error 0.
//  Period: H = N - N/2 high cycles, L = N/2 low cycles (N=3 -> 2 high/1 low).
//  Counter runs 0..N-1; o_clock_div = 1 for count 0..H-1, 0 for H..N-1 (registered).
//  FSM:
//   IDLE : o_clock_div 0, count 0. i_enable=1 -> RUN; on that edge count<=0,
//          o_clock_div<=1, o_tick<=1 (period starts one cycle after enable seen).
//   RUN  : count increments; at count==N-1: count<=0, o_clock_div<=1, o_tick<=1.
//          i_enable=0 -> DRAIN (no change to output that cycle).
//   DRAIN: continues counting to finish current period; i_enable=1 -> RUN with no
//          interruption; at count==N-1 with i_enable=0 -> IDLE, o_clock_div<=0,
//          no tick.
//  Ratio load: accept when i_div_valid & o_div_ready.
//   - value >= c_MIN_DIV: stored as pending; o_div_ready 0 from next cycle.
//   - value <  c_MIN_DIV: dropped, o_error<=1, o_div_ready stays 1.
//   - pending applied at next boundary (count==N-1 in RUN/DRAIN): o_active_div and N
//     update on that edge, so the new period starts with new N; in IDLE applied on the
//     cycle after acceptance. o_div_ready returns 1 the cycle after apply.
//   - i_div_valid while o_div_ready=0: ignored; requester must hold.
//  o_error: set wins over i_error_clear in the same cycle; otherwise clear -> 0.
//  Counter compare uses full c_WIDTH; N = 2^c_WIDTH-1 legal, no overflow (count<=N-1).
//  Reset mid-period: outputs return to reset values immediately; pending ratio lost.
// TESTING
//  1 Reset, enable=1, N=100 -> first tick 1 cycle after enable; o_clock_div 50 high,
//    50 low; ticks every 100 cycles; o_active_div=100.
//  2 N=3 loaded in IDLE then enable -> pattern 1,1,0 repeating; tick every 3 cycles.
//  3 Running N=10, load 4 at count 2 -> ready low, remainder of period uses 10,
//    next period 2 high/2 low, ready high one cycle after apply.
//  4 Offer N=1 and N=0 -> o_error 1, o_active_div unchanged; offer again with
//    i_error_clear=1 same cycle -> o_error stays 1; clear alone -> 0.
//  5 N=8, drop enable at count 1 -> period completes (4 high/4 low), then IDLE, no
//    tick; re-enable during DRAIN -> seamless continuation, no extra edge.
//  6 Assert i_reset_n=0 mid high phase with pending ratio -> o_clock_div 0
//    immediately, o_active_div=100, o_div_ready 1.

Source files
------------

// File: rtl/clock_divider.sv
// clock_divider: programmable integer clock divider with a rising-edge tick.
// The divide ratio can be reloaded at runtime through a valid/ready handshake.
// A new ratio only takes effect at a period boundary, so no runt or stretched
// pulse is ever produced in the middle of a period.
`timescale 1ns/1ps

module clock_divider #(
    parameter int unsigned              c_WIDTH       = 16,
    parameter logic [c_WIDTH-1:0]       c_DEFAULT_DIV = 16'd100,
    parameter logic [c_WIDTH-1:0]       c_MIN_DIV     = 16'd2
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_enable,
    input  logic [c_WIDTH-1:0] i_div_value,
    input  logic               i_div_valid,
    output logic               o_div_ready,
    input  logic               i_error_clear,
    output logic               o_clock_div,
    output logic               o_tick,
    output logic [c_WIDTH-1:0] o_active_div,
    output logic               o_error
);

    // Refuse to build with a reset ratio the divider itself would reject.
    generate
        if (c_DEFAULT_DIV < c_MIN_DIV) begin : g_bad_default
            $error("clock_divider: c_DEFAULT_DIV must be >= c_MIN_DIV");
        end
    endgenerate

    localparam logic [c_WIDTH-1:0] c_ONE = c_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_WIDTH-1:0] count_q, count_d;
    logic               clock_div_q, clock_div_d;
    logic               tick_q, tick_d;
    logic [c_WIDTH-1:0] active_div_q, active_div_d;
    logic [c_WIDTH-1:0] pending_q, pending_d;
    logic               pending_valid_q, pending_valid_d;
    logic               error_q, error_d;

    logic [c_WIDTH-1:0] half_high;
    logic [c_WIDTH-1:0] count_inc;
    logic               last_count;
    logic               accept;
    logic               apply;
    logic               error_set;

    // Next-state logic: period counter, output waveform, ratio handshake and error flag.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        clock_div_d     = clock_div_q;
        tick_d          = 1'b0;
        active_div_d    = active_div_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        error_d         = error_q;
        apply           = 1'b0;
        error_set       = 1'b0;

        half_high  = active_div_q - (active_div_q >> 1);
        count_inc  = count_q + c_ONE;
        last_count = (count_q == (active_div_q - c_ONE));
        accept     = i_div_valid && !pending_valid_q;

        case (state_q)
            S_IDLE: begin
                count_d     = '0;
                clock_div_d = 1'b0;
                apply       = pending_valid_q;
                if (i_enable) begin
                    state_d     = S_RUN;
                    clock_div_d = 1'b1;
                    tick_d      = 1'b1;
                end
            end
            S_RUN, S_DRAIN: begin
                if (last_count) begin
                    count_d = '0;
                    apply   = pending_valid_q;
                    if ((state_q == S_DRAIN) && !i_enable) begin
                        state_d     = S_IDLE;
                        clock_div_d = 1'b0;
                    end else begin
                        state_d     = i_enable ? S_RUN : S_DRAIN;
                        clock_div_d = 1'b1;
                        tick_d      = 1'b1;
                    end
                end else begin
                    count_d     = count_inc;
                    clock_div_d = (count_inc < half_high);
                    state_d     = i_enable ? S_RUN : S_DRAIN;
                end
            end
            default: begin
                state_d     = S_IDLE;
                count_d     = '0;
                clock_div_d = 1'b0;
            end
        endcase

        if (apply) begin
            active_div_d    = pending_q;
            pending_valid_d = 1'b0;
        end

        if (accept) begin
            if (i_div_value >= c_MIN_DIV) begin
                pending_d       = i_div_value;
                pending_valid_d = 1'b1;
            end else begin
                error_set = 1'b1;
            end
        end

        if (error_set) begin
            error_d = 1'b1;
        end else if (i_error_clear) begin
            error_d = 1'b0;
        end
    end

    // State registers; reset drops any pending ratio and restores the default.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q         <= S_IDLE;
            count_q         <= '0;
            clock_div_q     <= 1'b0;
            tick_q          <= 1'b0;
            active_div_q    <= c_DEFAULT_DIV;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            clock_div_q     <= clock_div_d;
            tick_q          <= tick_d;
            active_div_q    <= active_div_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            error_q         <= error_d;
        end
    end

    assign o_div_ready  = !pending_valid_q;
    assign o_clock_div  = clock_div_q;
    assign o_tick       = tick_q;
    assign o_active_div = active_div_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: directed bench for clock_divider. Stimulus pushes the
// expected tick cycle, active ratio and preceding high-phase length into a
// queue; a monitor pops an entry at every o_tick and compares.
`timescale 1ns/1ps

module tb_clock_divider;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [15:0] div_value;
    logic        div_valid;
    logic        div_ready;
    logic        error_clear;
    logic        clock_div;
    logic        tick;
    logic [15:0] active_div;
    logic        error_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int cyc;
        int active;
        int hi;
    } exp_t;

    exp_t exp_q[$];

    clock_divider dut (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .i_enable     (enable),
        .i_div_value  (div_value),
        .i_div_valid  (div_valid),
        .o_div_ready  (div_ready),
        .i_error_clear(error_clear),
        .o_clock_div  (clock_div),
        .o_tick       (tick),
        .o_active_div (active_div),
        .o_error      (error_flag)
    );

    // Free-running source clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle index: the number of rising edges seen so far.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic en, input int val, input logic valid, input logic clr);
        enable      = en;
        div_value   = 16'(val);
        div_valid   = valid;
        error_clear = clr;
    endtask

    task automatic pushTick(input int c, input int a, input int h);
        exp_t e;
        e.cyc    = c;
        e.active = a;
        e.hi     = h;
        exp_q.push_back(e);
    endtask

    task automatic stepTo(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: on each tick, compare against the oldest expectation.
    initial begin
        int   hi_cnt;
        exp_t e;
        hi_cnt = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                checkOutput("missed_tick", -1, e.cyc);
            end
            if (tick) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_tick", cyc, -1);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tick_cycle", cyc, e.cyc);
                    checkOutput("tick_active_div", int'(active_div), e.active);
                    if (e.hi >= 0) checkOutput("period_high", hi_cnt, e.hi);
                end
                hi_cnt = 1;
            end else if (clock_div) begin
                hi_cnt++;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int e;
        int b;
        int x;
        int y;
        int c;

        reset_n = 1'b0;
        applyStimulus(0, 100, 0, 0);
        stepTo(3);
        checkOutput("rst_clock_div", int'(clock_div), 0);
        checkOutput("rst_tick", int'(tick), 0);
        checkOutput("rst_active_div", int'(active_div), 100);
        checkOutput("rst_ready", int'(div_ready), 1);
        checkOutput("rst_error", int'(error_flag), 0);
        reset_n = 1'b1;
        stepTo(5);

        // Default ratio 100: 50 high / 50 low, tick every 100 cycles.
        e = cyc;
        pushTick(e + 1, 100, -1);
        pushTick(e + 101, 100, 50);
        pushTick(e + 201, 100, 50);
        applyStimulus(1, 100, 0, 0);
        stepTo(e + 50);
        checkOutput("n100_last_high", int'(clock_div), 1);
        stepTo(e + 51);
        checkOutput("n100_first_low", int'(clock_div), 0);
        stepTo(e + 250);
        applyStimulus(0, 100, 0, 0);
        stepTo(e + 300);
        checkOutput("n100_drain_low", int'(clock_div), 0);
        stepTo(e + 301);
        checkOutput("n100_idle", int'(clock_div), 0);

        // Ratio 3 loaded in IDLE: pattern 1,1,0.
        b = e + 302;
        stepTo(b);
        applyStimulus(0, 3, 1, 0);
        stepTo(b + 1);
        checkOutput("n3_ready_low", int'(div_ready), 0);
        applyStimulus(0, 3, 0, 0);
        stepTo(b + 2);
        checkOutput("n3_ready_back", int'(div_ready), 1);
        checkOutput("n3_active", int'(active_div), 3);
        pushTick(b + 3, 3, -1);
        pushTick(b + 6, 3, 2);
        pushTick(b + 9, 3, 2);
        pushTick(b + 12, 3, 2);
        applyStimulus(1, 3, 0, 0);
        stepTo(b + 12);
        applyStimulus(0, 3, 0, 0);

        // Ratio 10, then reload 4 mid-period.
        stepTo(b + 15);
        applyStimulus(0, 10, 1, 0);
        stepTo(b + 16);
        applyStimulus(0, 10, 0, 0);
        stepTo(b + 17);
        checkOutput("n10_active", int'(active_div), 10);
        pushTick(b + 18, 10, -1);
        pushTick(b + 28, 10, 5);
        pushTick(b + 38, 4, 5);
        pushTick(b + 42, 4, 2);
        pushTick(b + 46, 4, 2);
        applyStimulus(1, 10, 0, 0);
        stepTo(b + 30);
        applyStimulus(1, 4, 1, 0);
        stepTo(b + 31);
        checkOutput("reload_ready_low", int'(div_ready), 0);
        checkOutput("reload_active_old", int'(active_div), 10);
        applyStimulus(1, 4, 0, 0);
        stepTo(b + 37);
        checkOutput("reload_ready_before_apply", int'(div_ready), 0);
        checkOutput("reload_active_before_apply", int'(active_div), 10);
        stepTo(b + 38);
        checkOutput("reload_ready_after_apply", int'(div_ready), 1);
        checkOutput("reload_active_new", int'(active_div), 4);
        stepTo(b + 46);
        applyStimulus(0, 4, 0, 0);
        stepTo(b + 51);
        checkOutput("n4_idle", int'(clock_div), 0);

        // Illegal ratios and sticky error.
        x = cyc;
        applyStimulus(0, 1, 1, 0);
        stepTo(x + 1);
        checkOutput("err_set_n1", int'(error_flag), 1);
        checkOutput("err_ready_n1", int'(div_ready), 1);
        checkOutput("err_active_n1", int'(active_div), 4);
        applyStimulus(0, 0, 1, 0);
        stepTo(x + 2);
        checkOutput("err_set_n0", int'(error_flag), 1);
        checkOutput("err_ready_n0", int'(div_ready), 1);
        checkOutput("err_active_n0", int'(active_div), 4);
        applyStimulus(0, 1, 1, 1);
        stepTo(x + 3);
        checkOutput("err_set_wins", int'(error_flag), 1);
        applyStimulus(0, 0, 0, 1);
        stepTo(x + 4);
        checkOutput("err_cleared", int'(error_flag), 0);
        checkOutput("err_active_kept", int'(active_div), 4);
        applyStimulus(0, 0, 0, 0);
        stepTo(x + 5);

        // Ratio 8: drop enable at count 1, then re-enable during drain.
        y = cyc;
        applyStimulus(0, 8, 1, 0);
        stepTo(y + 1);
        applyStimulus(0, 8, 0, 0);
        stepTo(y + 2);
        checkOutput("n8_active", int'(active_div), 8);
        c = y + 2;
        pushTick(c + 1, 8, -1);
        pushTick(c + 11, 8, 4);
        pushTick(c + 19, 8, 4);
        pushTick(c + 27, 8, 4);
        pushTick(c + 35, 8, 4);
        applyStimulus(1, 8, 0, 0);
        stepTo(c + 2);
        applyStimulus(0, 8, 0, 0);
        stepTo(c + 4);
        checkOutput("drain_high", int'(clock_div), 1);
        stepTo(c + 5);
        checkOutput("drain_low", int'(clock_div), 0);
        stepTo(c + 8);
        checkOutput("drain_last_low", int'(clock_div), 0);
        stepTo(c + 9);
        checkOutput("drain_idle_clock", int'(clock_div), 0);
        checkOutput("drain_idle_tick", int'(tick), 0);
        stepTo(c + 10);
        applyStimulus(1, 8, 0, 0);
        stepTo(c + 20);
        applyStimulus(0, 8, 0, 0);
        stepTo(c + 22);
        applyStimulus(1, 8, 0, 0);

        // Reset in the high phase with a ratio pending.
        stepTo(c + 35);
        applyStimulus(1, 5, 1, 0);
        stepTo(c + 36);
        checkOutput("pend_ready_low", int'(div_ready), 0);
        applyStimulus(1, 5, 0, 0);
        stepTo(c + 37);
        checkOutput("pre_reset_high", int'(clock_div), 1);
        #1;
        reset_n = 1'b0;
        applyStimulus(0, 5, 0, 0);
        #1;
        checkOutput("async_rst_clock_div", int'(clock_div), 0);
        checkOutput("async_rst_tick", int'(tick), 0);
        checkOutput("async_rst_active", int'(active_div), 100);
        checkOutput("async_rst_ready", int'(div_ready), 1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        x = cyc;
        stepTo(x + 3);
        checkOutput("post_rst_ready", int'(div_ready), 1);
        checkOutput("post_rst_active", int'(active_div), 100);
        checkOutput("post_rst_clock_div", int'(clock_div), 0);
        stepTo(x + 13);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
